// File: rtl/alu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types for the registered ALU control unit.
//   alu_ctrl_e    : ALU control codes driven to the execute stage
//   aluop_e       : coarse operation class from the main decoder
//   state_e       : sequencing state of alu_ctrl_pipe
//   is_multicycle : true for codes that need the latency counter
// ----------------------------------------------------------------------------
package alu_ctrl_pkg;

    // Number of low op bits that carry the function code.
    localparam int FUNC_BITS = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLT = 4'd7,
        ALU_MUL = 4'd8,
        ALU_DIV = 4'd9
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        AOP_ADD  = 2'b00,
        AOP_SUB  = 2'b01,
        AOP_FUNC = 2'b10,
        AOP_PASS = 2'b11
    } aluop_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // MUL and DIV are the only codes that are sequenced over several cycles.
    function automatic logic is_multicycle(input alu_ctrl_e code);
        return (code == ALU_MUL) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctrl_decode
// Pure combinational decode of op/aluop into an ALU control code.
// Ports:
//   i_op         : function field, only the low 4 bits select a code
//   i_aluop      : 00 ADD, 01 SUB, 10 decode op, 11 pass op through
//   o_ctrl       : ALU control code (CTRL_W bits)
//   o_illegal    : op could not be decoded (only reported with the trap enabled)
//   o_multicycle : code needs the multi-cycle sequencer (MUL/DIV)
// Configuration macro: ALU_ILLEGAL_TRAP_EN
//   defined     : o_illegal flags undecodable ops
//   not defined : o_illegal tied 0; undecodable ops still map to ADD
// ----------------------------------------------------------------------------
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 5,
    parameter int CTRL_W = 4
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [1:0]        i_aluop,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_illegal,
    output logic              o_multicycle
);

    // Zero-extended op so the pass-through slice and the upper-bit check
    // stay legal for any OP_W / CTRL_W combination.
    logic [OP_W+CTRL_W-1:0] w_opExt;
    logic                   w_upperSet;
    logic                   w_bad;
    alu_ctrl_e              w_code;

    assign w_opExt    = {{CTRL_W{1'b0}}, i_op};
    assign w_upperSet = |(w_opExt >> FUNC_BITS);

    // Function codes 10..15, or any op bit above bit 3, cannot be decoded and
    // fall back to ADD so the execute stage always sees a harmless operation.
    always_comb begin
        o_ctrl       = '0;
        o_multicycle = 1'b0;
        w_bad        = 1'b0;
        w_code       = ALU_ADD;
        case (aluop_e'(i_aluop))
            AOP_ADD:  o_ctrl = CTRL_W'(ALU_ADD);
            AOP_SUB:  o_ctrl = CTRL_W'(ALU_SUB);
            AOP_FUNC: begin
                if (w_upperSet || (i_op[FUNC_BITS-1:0] > 4'd9)) begin
                    w_bad  = 1'b1;
                    o_ctrl = CTRL_W'(ALU_ADD);
                end else begin
                    w_code       = alu_ctrl_e'(i_op[FUNC_BITS-1:0]);
                    o_ctrl       = CTRL_W'(w_code);
                    o_multicycle = is_multicycle(w_code);
                end
            end
            AOP_PASS: o_ctrl = w_opExt[CTRL_W-1:0];
            default:  o_ctrl = CTRL_W'(ALU_ADD);
        endcase
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    assign o_illegal = w_bad;
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// alu_ctrl_pipe
// Registered, handshaked ALU control unit between the main decoder and the
// execute stage. Holds one result; MUL/DIV are sequenced by a latency counter.
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : op/aluop handshake from the decoder
//   op, aluop            : operation to decode
//   out_valid / out_ready: result handshake to the execute stage
//   alucontrol           : registered ALU control code
//   busy                 : multi-cycle op in progress
//   illegal              : held result came from an undecodable op
// Configuration macro: ALU_ILLEGAL_TRAP_EN (enables the illegal flag).
// ----------------------------------------------------------------------------
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int CTRL_W  = 4,
    parameter int MUL_CYC = 3,
    parameter int DIV_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              busy,
    output logic              illegal
);

    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_outValid;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_illegal;

    state_e            w_stateNext;
    logic [CNT_W-1:0]  w_countNext;
    logic              w_outValidNext;
    logic [CTRL_W-1:0] w_ctrlNext;
    logic              w_illegalNext;

    logic [CTRL_W-1:0] w_ctrl;
    logic              w_illegal;
    logic              w_multi;
    logic              w_transfer;
    logic [CNT_W-1:0]  w_latLoad;
    logic              w_goBusy;

    alu_ctrl_decode #(
        .OP_W   (OP_W),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .i_op         (op),
        .i_aluop      (aluop),
        .o_ctrl       (w_ctrl),
        .o_illegal    (w_illegal),
        .o_multicycle (w_multi)
    );

    // Reset gates in_ready so nothing is taken while reset is held.
    assign in_ready   = !reset && (r_state == IDLE) && (!r_outValid || out_ready);
    assign w_transfer = in_valid && in_ready;

    // A one-cycle latency op never enters BUSY.
    assign w_latLoad = (w_ctrl == CTRL_W'(ALU_DIV)) ? DIV_LOAD : MUL_LOAD;
    assign w_goBusy  = w_multi && (w_latLoad != '0);

    // State, counter and output register; everything resets together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_count    <= w_countNext;
            r_outValid <= w_outValidNext;
            r_ctrl     <= w_ctrlNext;
            r_illegal  <= w_illegalNext;
        end
    end

    // Next-state logic. The code is captured at accept time even for MUL/DIV;
    // out_valid stays low until the counter expires. Leaving BUSY on the
    // 1 -> 0 step gives exactly LAT edges from accept to out_valid.
    always_comb begin
        w_stateNext    = r_state;
        w_countNext    = r_count;
        w_outValidNext = r_outValid;
        w_ctrlNext     = r_ctrl;
        w_illegalNext  = r_illegal;
        if (r_outValid && out_ready) begin
            w_outValidNext = 1'b0;
        end
        case (r_state)
            IDLE: begin
                if (w_transfer) begin
                    w_ctrlNext    = w_ctrl;
                    w_illegalNext = w_illegal;
                    if (w_goBusy) begin
                        w_stateNext    = BUSY;
                        w_countNext    = w_latLoad;
                        w_outValidNext = 1'b0;
                    end else begin
                        w_outValidNext = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (r_count <= CNT_W'(1)) begin
                    w_stateNext    = IDLE;
                    w_countNext    = '0;
                    w_outValidNext = 1'b1;
                end else begin
                    w_countNext = r_count - CNT_W'(1);
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign out_valid  = r_outValid;
    assign alucontrol = r_ctrl;
    assign busy       = (r_state == BUSY);
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_ctrl_pipe
// Directed bench for alu_ctrl_pipe with default parameters
// (MUL latency 3, DIV latency 8). Inputs change and outputs are sampled on
// the falling edge. Honours ALU_ILLEGAL_TRAP_EN for the illegal flag.
// ----------------------------------------------------------------------------
module tb_alu_ctrl_pipe;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] op;
    logic [1:0] aluop;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alucontrol;
    logic       busy;
    logic       illegal;

    int vectors;
    int miscompares;

`ifdef ALU_ILLEGAL_TRAP_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    alu_ctrl_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .aluop      (aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alucontrol (alucontrol),
        .busy       (busy),
        .illegal    (illegal)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs and let one rising edge pass.
    task automatic applyStimulus(input logic v, input logic [1:0] a,
                                 input logic [4:0] o, input logic r);
        in_valid  = v;
        aluop     = a;
        op        = o;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held two cycles with in_valid high
        reset = 1'b1;
        applyStimulus(1'b1, 2'b10, 5'd3, 1'b1);
        checkOutput("rst1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst1_busy",      32'(busy),      32'd0);
        checkOutput("rst1_in_ready",  32'(in_ready),  32'd0);
        checkOutput("rst1_ctrl",      32'(alucontrol), 32'd0);
        applyStimulus(1'b1, 2'b10, 5'd3, 1'b1);
        checkOutput("rst2_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst2_in_ready",  32'(in_ready),  32'd0);
        checkOutput("rst2_illegal",   32'(illegal),   32'd0);

        // OR with latency 1
        reset = 1'b0;
        applyStimulus(1'b1, 2'b10, 5'b00011, 1'b1);
        checkOutput("or_out_valid", 32'(out_valid),  32'd1);
        checkOutput("or_ctrl",      32'(alucontrol), 32'd3);
        checkOutput("or_in_ready",  32'(in_ready),   32'd1);

        // Back-to-back ops 0..7, one result per cycle
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'b10, 5'(i), 1'b1);
            checkOutput($sformatf("b2b%0d_valid", i), 32'(out_valid),  32'd1);
            checkOutput($sformatf("b2b%0d_ctrl", i),  32'(alucontrol), 32'(i));
        end
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

        // MUL: busy two cycles, result on the third
        applyStimulus(1'b1, 2'b10, 5'b01000, 1'b1);
        checkOutput("mul_c1_busy",     32'(busy),      32'd1);
        checkOutput("mul_c1_valid",    32'(out_valid), 32'd0);
        checkOutput("mul_c1_in_ready", 32'(in_ready),  32'd0);
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        checkOutput("mul_c2_busy",  32'(busy),      32'd1);
        checkOutput("mul_c2_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        checkOutput("mul_c3_valid", 32'(out_valid),  32'd1);
        checkOutput("mul_c3_ctrl",  32'(alucontrol), 32'd8);
        checkOutput("mul_c3_busy",  32'(busy),       32'd0);

        // DIV accepted while the MUL result is consumed; result on cycle 8
        applyStimulus(1'b1, 2'b10, 5'b01001, 1'b1);
        checkOutput("div_c1_busy",  32'(busy),      32'd1);
        checkOutput("div_c1_valid", 32'(out_valid), 32'd0);
        for (int k = 2; k < 8; k++) begin
            applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
            checkOutput($sformatf("div_c%0d_busy", k),  32'(busy),      32'd1);
            checkOutput($sformatf("div_c%0d_valid", k), 32'(out_valid), 32'd0);
        end
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        checkOutput("div_c8_valid", 32'(out_valid),  32'd1);
        checkOutput("div_c8_ctrl",  32'(alucontrol), 32'd9);
        checkOutput("div_c8_busy",  32'(busy),       32'd0);

        // ADD (op ignored) loaded while DIV result is consumed, then stalled
        applyStimulus(1'b1, 2'b00, 5'd7, 1'b1);
        checkOutput("add_valid", 32'(out_valid),  32'd1);
        checkOutput("add_ctrl",  32'(alucontrol), 32'd0);
        applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
        checkOutput("stall1_valid",    32'(out_valid),  32'd1);
        checkOutput("stall1_ctrl",     32'(alucontrol), 32'd0);
        checkOutput("stall1_in_ready", 32'(in_ready),   32'd0);
        applyStimulus(1'b1, 2'b01, 5'd0, 1'b0);
        checkOutput("stall2_valid",    32'(out_valid),  32'd1);
        checkOutput("stall2_ctrl",     32'(alucontrol), 32'd0);
        checkOutput("stall2_in_ready", 32'(in_ready),   32'd0);

        // Consume and load SUB in the same cycle
        in_valid  = 1'b1;
        aluop     = 2'b01;
        op        = 5'd0;
        out_ready = 1'b1;
        #1;
        checkOutput("sub_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("sub_valid", 32'(out_valid),  32'd1);
        checkOutput("sub_ctrl",  32'(alucontrol), 32'd1);

        // Pass-through of op[3:0]
        applyStimulus(1'b1, 2'b11, 5'b01101, 1'b1);
        checkOutput("pass_ctrl",    32'(alucontrol), 32'd13);
        checkOutput("pass_illegal", 32'(illegal),    32'd0);

        // Illegal ops fall back to ADD
        applyStimulus(1'b1, 2'b10, 5'b10010, 1'b1);
        checkOutput("ill_upper_ctrl",    32'(alucontrol), 32'd0);
        checkOutput("ill_upper_illegal", 32'(illegal),    32'(EXP_ILL));
        checkOutput("ill_upper_busy",    32'(busy),       32'd0);
        applyStimulus(1'b1, 2'b10, 5'b01100, 1'b1);
        checkOutput("ill_12_ctrl",    32'(alucontrol), 32'd0);
        checkOutput("ill_12_illegal", 32'(illegal),    32'(EXP_ILL));
        applyStimulus(1'b1, 2'b10, 5'd4, 1'b1);
        checkOutput("xor_ctrl",    32'(alucontrol), 32'd4);
        checkOutput("xor_illegal", 32'(illegal),    32'd0);
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        checkOutput("idle_valid", 32'(out_valid), 32'd0);

        // Reset in cycle 4 of a DIV abandons it
        applyStimulus(1'b1, 2'b10, 5'b01001, 1'b1);
        checkOutput("rdiv_c1_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        checkOutput("rdiv_c3_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
        checkOutput("rdiv_rst_busy",  32'(busy),      32'd0);
        checkOutput("rdiv_rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 2'b10, 5'd0, 1'b1);
            checkOutput($sformatf("rdiv_post%0d_valid", k), 32'(out_valid), 32'd0);
        end
        in_valid  = 1'b1;
        aluop     = 2'b00;
        op        = 5'd0;
        out_ready = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("post_rst_add_valid", 32'(out_valid),  32'd1);
        checkOutput("post_rst_add_ctrl",  32'(alucontrol), 32'd0);
        checkOutput("post_rst_add_busy",  32'(busy),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
